// File: rtl/kbd_event_ctrl.sv
// PS/2 set-2 scan-code consumer: pops the keyboard FIFO and tracks the held key.
// Define KBD_SHIFT_EN to add left/right shift tracking and uppercase letters.
module kbd_event_ctrl #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         kb_data,
  input  logic               kb_ready,
  input  logic               kb_overflow,
  output logic               kb_nextdata_n,
  output logic               key_down,
  output logic [7:0]         cur_code,
  output logic               extended,
  output logic [7:0]         cur_ascii,
  output logic [COUNT_W-1:0] key_count,
  output logic               ovf_seen
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT
  } state_t;

  state_t state;
  logic   ext_pending;
  logic   brk_pending;
  logic   is_drop;
  logic   same_key;
  logic   shift_on;

  function automatic logic [7:0] code2ascii(input logic [7:0] c);
    logic [7:0] a;
    case (c)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;
      8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;
      8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;
      8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;
      8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;
      8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;
      8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;
      8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;
      8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  always_comb begin
    is_drop = 1'b0;
    unique case (1'b1)
      kb_data == 8'h00,
      kb_data == 8'hAA,
      kb_data == 8'hE1,
      kb_data == 8'hEE,
      kb_data == 8'hFA,
      kb_data == 8'hFE,
      kb_data == 8'hFF: is_drop = 1'b1;
      default:          is_drop = 1'b0;
    endcase
  end

  assign same_key = key_down
                 && (kb_data == cur_code)
                 && (ext_pending == extended);

`ifdef KBD_SHIFT_EN
  logic [1:0] shift_q;
  logic       is_shift;

  assign is_shift = !ext_pending
                 && (kb_data == 8'h12 || kb_data == 8'h59);
  assign shift_on = |shift_q;
`else
  assign shift_on = 1'b0;
`endif

  always_comb begin
    cur_ascii = code2ascii(cur_code);
    if (extended)
      cur_ascii = 8'h00;
    else if (shift_on && cur_ascii >= 8'h61 && cur_ascii <= 8'h7A)
      cur_ascii = cur_ascii - 8'h20;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      kb_nextdata_n <= 1'b1;
      key_down      <= 1'b0;
      cur_code      <= 8'h00;
      extended      <= 1'b0;
      key_count     <= '0;
      ovf_seen      <= 1'b0;
      ext_pending   <= 1'b0;
      brk_pending   <= 1'b0;
`ifdef KBD_SHIFT_EN
      shift_q       <= 2'b00;
`endif
    end else begin
      if (kb_overflow)
        ovf_seen <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (kb_ready) begin
            state         <= ST_POP;
            kb_nextdata_n <= 1'b0;
            if (kb_data == 8'hE0) begin
              ext_pending <= 1'b1;
            end else if (kb_data == 8'hF0) begin
              brk_pending <= 1'b1;
            end else begin
              ext_pending <= 1'b0;
              brk_pending <= 1'b0;
              if (!is_drop) begin
`ifdef KBD_SHIFT_EN
                if (is_shift) begin
                  if (kb_data == 8'h12)
                    shift_q[0] <= !brk_pending;
                  else
                    shift_q[1] <= !brk_pending;
                end else
`endif
                if (brk_pending) begin
                  if (same_key)
                    key_down <= 1'b0;
                end else if (!same_key) begin
                  // typematic repeats of the held key fall through
                  key_down  <= 1'b1;
                  cur_code  <= kb_data;
                  extended  <= ext_pending;
                  key_count <= key_count + COUNT_W'(1);
                end
              end
            end
          end
        end
        ST_POP: begin
          kb_nextdata_n <= 1'b1;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          state <= ST_IDLE;
        end
        default: begin
          state         <= ST_IDLE;
          kb_nextdata_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Scoreboard bench for kbd_event_ctrl: each pop strobe or snapshot request
// is checked against a hand-computed expected state queued by the stimulus.
module tb_kbd_event_ctrl;

  logic       clk;
  logic       resetn;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       kb_nextdata_n;
  logic       key_down;
  logic [7:0] cur_code;
  logic       extended;
  logic [7:0] cur_ascii;
  logic [7:0] key_count;
  logic       ovf_seen;

  kbd_event_ctrl #(.COUNT_W(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .kb_data      (kb_data),
    .kb_ready     (kb_ready),
    .kb_overflow  (kb_overflow),
    .kb_nextdata_n(kb_nextdata_n),
    .key_down     (key_down),
    .cur_code     (cur_code),
    .extended     (extended),
    .cur_ascii    (cur_ascii),
    .key_count    (key_count),
    .ovf_seen     (ovf_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       kd;
    logic [7:0] code;
    logic       ext;
    logic [7:0] asc;
    logic [7:0] cnt;
    logic       ovf;
    logic       snap;
  } exp_t;

  exp_t sb[$];
  int   snap_cnt = 0;
  logic done = 1'b0;
  logic ovf_exp = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   snap_seen = 0;
  int   cyc = 0;
  int   last_pop = -100;
  logic prev_low = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    logic [26:0] act;
    logic [26:0] req;
    cyc = cyc + 1;
    act = {key_down, cur_code, extended, cur_ascii,
           key_count, ovf_seen, kb_nextdata_n};
    if (!kb_nextdata_n) begin
      checks = checks + 1;
      if (prev_low || (cyc - last_pop) < 3) begin
        errors = errors + 1;
        $display("FAIL pop_spacing: gap=%0d cycles, required >=3",
                 cyc - last_pop);
      end
      last_pop = cyc;
      checks = checks + 1;
      if (sb.size() == 0 || sb[0].snap) begin
        errors = errors + 1;
        $display("FAIL unexpected_pop: got pop strobe, required none");
      end else begin
        e = sb.pop_front();
        req = {e.kd, e.code, e.ext, e.asc, e.cnt, e.ovf, 1'b0};
        if (act !== req) begin
          errors = errors + 1;
          $display("FAIL pop_state: got %h, required %h", act, req);
        end
      end
    end
    prev_low = !kb_nextdata_n;
    if (snap_cnt != snap_seen) begin
      snap_seen = snap_cnt;
      checks = checks + 1;
      if (sb.size() == 0 || !sb[0].snap) begin
        errors = errors + 1;
        $display("FAIL snapshot_order: no snapshot entry at head");
      end else begin
        e = sb.pop_front();
        req = {e.kd, e.code, e.ext, e.asc, e.cnt, e.ovf, 1'b1};
        if (act !== req) begin
          errors = errors + 1;
          $display("FAIL snapshot: got %h, required %h", act, req);
        end
      end
    end
    if (done || cyc > 30000) begin
      checks = checks + 1;
      if (!done || sb.size() != 0) begin
        errors = errors + 1;
        $display("FAIL drain: %0d entries left, done=%0d, required 0/1",
                 sb.size(), done);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic send(input logic [7:0] b, input logic kd,
                      input logic [7:0] code, input logic ext,
                      input logic [7:0] asc, input logic [7:0] cnt);
    sb.push_back('{kd, code, ext, asc, cnt, ovf_exp, 1'b0});
    @(negedge clk);
    kb_data  = b;
    kb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!kb_nextdata_n) break;
    end
    kb_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic snap(input logic kd, input logic [7:0] code,
                      input logic ext, input logic [7:0] asc,
                      input logic [7:0] cnt);
    @(posedge clk);
    #1;
    sb.push_back('{kd, code, ext, asc, cnt, ovf_exp, 1'b1});
    snap_cnt = snap_cnt + 1;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    kb_ready = 1'b0;
    ovf_exp  = 1'b0;
    snap(0, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    resetn      = 1'b0;
    kb_data     = 8'h00;
    kb_ready    = 1'b0;
    kb_overflow = 1'b0;
    snap(0, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    send(8'h1C, 1, 8'h1C, 0, 8'h61, 8'd1);
    send(8'hF0, 1, 8'h1C, 0, 8'h61, 8'd1);
    send(8'h1C, 0, 8'h1C, 0, 8'h61, 8'd1);

    do_reset();
    send(8'h16, 1, 8'h16, 0, 8'h31, 8'd1);
    send(8'h16, 1, 8'h16, 0, 8'h31, 8'd1);
    send(8'h16, 1, 8'h16, 0, 8'h31, 8'd1);
    send(8'hF0, 1, 8'h16, 0, 8'h31, 8'd1);
    send(8'h16, 0, 8'h16, 0, 8'h31, 8'd1);

    do_reset();
    send(8'hE0, 0, 8'h00, 0, 8'h00, 8'd0);
    send(8'h75, 1, 8'h75, 1, 8'h00, 8'd1);
    send(8'hF0, 1, 8'h75, 1, 8'h00, 8'd1);
    send(8'h75, 1, 8'h75, 1, 8'h00, 8'd1);
    send(8'hE0, 1, 8'h75, 1, 8'h00, 8'd1);
    send(8'hF0, 1, 8'h75, 1, 8'h00, 8'd1);
    send(8'h75, 0, 8'h75, 1, 8'h00, 8'd1);

    do_reset();
    for (int i = 0; i < 255; i++) begin
      logic [7:0] n;
      n = 8'(i + 1);
      if (i % 2 == 0) send(8'h1C, 1, 8'h1C, 0, 8'h61, n);
      else            send(8'h32, 1, 8'h32, 0, 8'h62, n);
    end
    send(8'h21, 1, 8'h21, 0, 8'h63, 8'h00);
    send(8'hFA, 1, 8'h21, 0, 8'h63, 8'h00);
    send(8'hAA, 1, 8'h21, 0, 8'h63, 8'h00);
    send(8'hE0, 1, 8'h21, 0, 8'h63, 8'h00);
    send(8'hAA, 1, 8'h21, 0, 8'h63, 8'h00);
    send(8'h21, 1, 8'h21, 0, 8'h63, 8'h00);

    do_reset();
`ifdef KBD_SHIFT_EN
    send(8'h12, 0, 8'h00, 0, 8'h00, 8'd0);
    send(8'h1C, 1, 8'h1C, 0, 8'h41, 8'd1);
    send(8'hF0, 1, 8'h1C, 0, 8'h41, 8'd1);
    send(8'h12, 1, 8'h1C, 0, 8'h61, 8'd1);
`else
    send(8'h12, 1, 8'h12, 0, 8'h00, 8'd1);
    send(8'h1C, 1, 8'h1C, 0, 8'h61, 8'd2);
    send(8'hF0, 1, 8'h1C, 0, 8'h61, 8'd2);
    send(8'h12, 1, 8'h1C, 0, 8'h61, 8'd2);
`endif

    do_reset();
    @(negedge clk);
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    ovf_exp     = 1'b1;
    snap(0, 8'h00, 0, 8'h00, 8'h00);
    send(8'hF0, 0, 8'h00, 0, 8'h00, 8'd0);
    do_reset();
    send(8'h1C, 1, 8'h1C, 0, 8'h61, 8'd1);

    @(negedge clk);
    kb_data  = 8'h16;
    kb_ready = 1'b1;
    @(posedge clk);
    #1;
    resetn   = 1'b0;
    kb_ready = 1'b0;
    ovf_exp  = 1'b0;
    snap(0, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    snap(0, 8'h00, 0, 8'h00, 8'h00);
    send(8'h1C, 1, 8'h1C, 0, 8'h61, 8'd1);

    repeat (3) @(negedge clk);
    #1;
    done = 1'b1;
  end

endmodule
